// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared opcodes, instruction field positions and FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W_DEF = 16;

    // ALU opcodes; opcode 0 doubles as the controller's NOP
    localparam logic [3:0] OP_IDLE = 4'd0;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SL   = 4'd6;
    localparam logic [3:0] OP_SR   = 4'd7;
    localparam logic [3:0] OP_GT   = 4'd8;
    localparam logic [3:0] OP_LT   = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_LDI  = 4'd11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_WB    = 3'd3;
    localparam state_t ST_FAULT = 3'd4;

    function automatic logic is_alu_op(input logic [3:0] opc);
        return (opc >= OP_ADD) && (opc <= OP_EQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_8x16.sv
// ============================================================================
//  Module   : regfile_8x16
//  Purpose  : 8-entry register file, two read ports, debug read, one write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_8x16
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [2:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] w_regs [8];

    // r0 has no storage, so writes addressed to it simply vanish
    assign w_regs[0] = '0;

    for (genvar i = 1; i < 8; i++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                r_q <= '0;
            end else if (we && (wr_addr == 3'(i))) begin
                r_q <= wr_data;
            end
        end
        assign w_regs[i] = r_q;
    end

    assign ra_data  = w_regs[ra_addr];
    assign rb_data  = w_regs[rb_addr];
    assign dbg_data = w_regs[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Accepts instructions, issues them to the registered ALU, retires.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] result,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] c_WAIT_INIT = 2'(ALU_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_opc;
    logic [2:0]        r_rd;
    logic [8:0]        r_imm;
    logic [1:0]        r_cnt;
    logic [3:0]        w_opc;
    logic              w_accept;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_wdata;

    assign w_opc    = instr[OPC_MSB:OPC_LSB];
    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_we     = (r_state == ST_WB) && (r_opc != OP_NOP);
    assign w_wdata  = (r_opc == OP_LDI) ? {{(DATA_W-9){1'b0}}, r_imm} : alu_out;

    regfile_8x16 #(.DATA_W(DATA_W)) u_regfile (
        .CLK      (CLK),
        .reset    (reset),
        .ra_addr  (instr[RA_MSB:RA_LSB]),
        .ra_data  (w_rd_a),
        .rb_addr  (instr[RB_MSB:RB_LSB]),
        .rb_data  (w_rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (w_we),
        .wr_addr  (r_rd),
        .wr_data  (w_wdata)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_alu_op(w_opc)) begin
                        w_next = ST_ISSUE;
                    end else if ((w_opc == OP_LDI) || (w_opc == OP_NOP)) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_FAULT;
                    end
                end
            end
            ST_ISSUE: w_next = (ALU_LAT == 1) ? ST_WB : ST_WAIT;
            ST_WAIT:  if (r_cnt == 2'd1) w_next = ST_WB;
            ST_WB:    w_next = ST_IDLE;
            ST_FAULT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (r_state == ST_IDLE);
        alu_op      = (r_state == ST_ISSUE) ? r_opc : OP_IDLE;
        done        = (r_state == ST_WB);
        illegal     = (r_state == ST_FAULT);
    end

    // Operands are captured at accept and held until the next accept
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_opc  <= OP_NOP;
            r_rd   <= '0;
            r_imm  <= '0;
            r_cnt  <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            result <= '0;
        end else begin
            if (w_accept) begin
                r_opc <= w_opc;
                r_rd  <= instr[RD_MSB:RD_LSB];
                r_imm <= instr[IMM_MSB:IMM_LSB];
                alu_a <= w_rd_a;
                alu_b <= w_rd_b;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= c_WAIT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_we) begin
                result <= w_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Directed + random bench for alu_issue_ctrl at ALU_LAT 1 and 3.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    logic [1:0]       instr_valid;
    logic [1:0]       instr_ready;
    logic [1:0][15:0] instr;
    logic [1:0][3:0]  alu_op;
    logic [1:0][15:0] alu_a;
    logic [1:0][15:0] alu_b;
    logic [1:0][15:0] alu_out;
    logic [1:0]       done;
    logic [1:0]       illegal;
    logic [1:0][15:0] result;
    logic [1:0][2:0]  dbg_addr;
    logic [1:0][15:0] dbg_data;

    int n_vec  = 0;
    int n_fail = 0;

    // Architectural view of each instance: eight registers and the last retired value
    logic [15:0] m_reg [2][8];
    logic [15:0] m_result [2];

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[3:0];
            4'd7:    return a >> b[3:0];
            4'd8:    return {15'd0, a > b};
            4'd9:    return {15'd0, a < b};
            4'd10:   return {15'd0, a == b};
            default: return 16'd0;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [15:0] pipe [4];

        alu_issue_ctrl #(.DATA_W(16), .ALU_LAT(LAT)) u_dut (
            .CLK         (CLK),
            .reset       (reset),
            .instr_valid (instr_valid[k]),
            .instr_ready (instr_ready[k]),
            .instr       (instr[k]),
            .alu_op      (alu_op[k]),
            .alu_a       (alu_a[k]),
            .alu_b       (alu_b[k]),
            .alu_out     (alu_out[k]),
            .done        (done[k]),
            .illegal     (illegal[k]),
            .result      (result[k]),
            .dbg_addr    (dbg_addr[k]),
            .dbg_data    (dbg_data[k])
        );

        // Registered ALU: result visible LAT edges after the sampling edge, held while op is 0
        always @(posedge CLK) begin
            if (alu_op[k] != 4'd0) pipe[0] <= alu_f(alu_op[k], alu_a[k], alu_b[k]);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign alu_out[k] = pipe[LAT-1];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input int k);
        for (int i = 0; i < 8; i++) begin
            dbg_addr[k] = 3'(i);
            #1;
            check($sformatf("reg%0d_u%0d", i, k), dbg_data[k], m_reg[k][i]);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] opc, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
        return {opc, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'd11, rd, imm};
    endfunction

    task automatic run_instr(input int k, input logic [15:0] ins);
        logic [3:0]  opc;
        logic [2:0]  rd;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] wdata;
        bit          is_alu;
        bit          is_ill;
        bit          ended;
        int          lat;
        int          exp_cyc;
        int          cyc;
        opc     = ins[15:12];
        rd      = ins[11:9];
        ea      = m_reg[k][ins[8:6]];
        eb      = m_reg[k][ins[5:3]];
        lat     = (k == 0) ? 1 : 3;
        is_alu  = (opc >= 4'd1) && (opc <= 4'd10);
        is_ill  = (opc >= 4'd12);
        exp_cyc = is_alu ? 1 + lat : 1;

        @(negedge CLK);
        check("ready_idle", 16'(instr_ready[k]), 16'd1);
        instr_valid[k] = 1'b1;
        instr[k]       = ins;
        @(posedge CLK);
        #1;
        instr_valid[k] = 1'b0;
        instr[k]       = 16'($urandom);

        cyc   = 0;
        ended = 1'b0;
        while (!ended && cyc < 8) begin
            cyc++;
            check("alu_op", 16'(alu_op[k]), (is_alu && cyc == 1) ? 16'(opc) : 16'd0);
            check("ready_busy", 16'(instr_ready[k]), 16'd0);
            if (is_alu && cyc == 1) begin
                check("alu_a", alu_a[k], ea);
                check("alu_b", alu_b[k], eb);
            end
            if (done[k] || illegal[k]) begin
                ended = 1'b1;
            end else begin
                @(posedge CLK);
                #1;
            end
        end
        check("retire_seen", 16'(ended), 16'd1);
        check("latency", 16'(cyc), 16'(exp_cyc));
        check("done", 16'(done[k]), is_ill ? 16'd0 : 16'd1);
        check("illegal", 16'(illegal[k]), is_ill ? 16'd1 : 16'd0);

        if (is_alu || opc == 4'd11) begin
            wdata = is_alu ? alu_f(opc, ea, eb) : {7'd0, ins[8:0]};
            if (rd != 3'd0) m_reg[k][rd] = wdata;
            m_result[k] = wdata;
        end

        @(posedge CLK);
        #1;
        check("done_pulse", 16'(done[k]), 16'd0);
        check("illegal_pulse", 16'(illegal[k]), 16'd0);
        check("ready_back", 16'(instr_ready[k]), 16'd1);
        check("result", result[k], m_result[k]);
        check_regs(k);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = '0;
        instr       = '0;
        dbg_addr    = '0;
        for (int k = 0; k < 2; k++) begin
            m_result[k] = 16'd0;
            for (int i = 0; i < 8; i++) m_reg[k][i] = 16'd0;
        end

        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 16'(instr_ready[k]), 16'd1);
            check("rst_alu_op", 16'(alu_op[k]), 16'd0);
            check("rst_alu_a", alu_a[k], 16'd0);
            check("rst_alu_b", alu_b[k], 16'd0);
            check("rst_done", 16'(done[k]), 16'd0);
            check("rst_illegal", 16'(illegal[k]), 16'd0);
            check("rst_result", result[k], 16'd0);
            check_regs(k);
        end
        @(negedge CLK);
        reset = 1'b0;

        for (int k = 0; k < 2; k++) begin
            run_instr(k, ldi(3'd1, 9'd5));
            run_instr(k, ldi(3'd2, 9'd3));
            run_instr(k, mk(4'd1, 3'd3, 3'd1, 3'd2));
            run_instr(k, mk(4'd2, 3'd4, 3'd2, 3'd1));
            run_instr(k, mk(4'd8, 3'd5, 3'd1, 3'd2));
            run_instr(k, mk(4'd10, 3'd6, 3'd1, 3'd1));
            run_instr(k, ldi(3'd0, 9'd7));
            run_instr(k, mk(4'd13, 3'd7, 3'd1, 3'd2));
            run_instr(k, mk(4'd0, 3'd3, 3'd0, 3'd0));
            run_instr(k, ldi(3'd7, 9'h1FF));
            for (int n = 0; n < 40; n++) begin
                run_instr(k, {4'($urandom_range(0, 15)), 12'($urandom)});
            end
        end

        // Rebuild known operands, then hit reset while the ADD sits in ISSUE
        run_instr(0, ldi(3'd1, 9'd5));
        run_instr(0, ldi(3'd2, 9'd3));
        @(negedge CLK);
        instr_valid[0] = 1'b1;
        instr[0]       = mk(4'd1, 3'd7, 3'd1, 3'd2);
        @(posedge CLK);
        #1;
        instr_valid[0] = 1'b0;
        check("rst_mid_issue", 16'(alu_op[0]), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_ready", 16'(instr_ready[0]), 16'd1);
        check("rst_mid_alu_op", 16'(alu_op[0]), 16'd0);
        check("rst_mid_done", 16'(done[0]), 16'd0);
        for (int k = 0; k < 2; k++) begin
            m_result[k] = 16'd0;
            for (int i = 0; i < 8; i++) m_reg[k][i] = 16'd0;
        end
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK);
            #1;
            check("post_rst_ready", 16'(instr_ready[0]), 16'd1);
            check("post_rst_done", 16'(done[0]), 16'd0);
            check("post_rst_illegal", 16'(illegal[0]), 16'd0);
        end
        check("post_rst_result", result[0], m_result[0]);
        check_regs(0);
        check_regs(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction-side initiator for the CPU's registered ALU. It accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives op/in_a/in_b to the ALU, waits out the ALU's registered latency, and writes the result back to the destination register.
- Sits between the fetch/decode front end and the ALU. It is the only block that drives ALU inputs.

Parameters:
- DATA_W, 16: datapath and register width. Only 16 is supported by the instruction format.
- ALU_LAT, 1: cycles from the edge that samples alu_op to alu_out being valid. Legal range 1..4.

Ports:
- CLK  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  16  [15:12] opc, [11:9] rd, [8:6] ra, [5:3] rb; LDI uses [8:0] imm9
- alu_op  out  4  op code to ALU: 0 IDLE, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 XOR, 6 SL, 7 SR, 8 GT, 9 LT, 10 EQ
- alu_a  out  16  ALU operand a
- alu_b  out  16  ALU operand b
- alu_out  in  16  ALU registered result
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, opcode 12..15 rejected
- result  out  16  value retired with the last done (held)
- dbg_addr  in  3  debug register read address
- dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async) values: state=IDLE, all regs=0, alu_op=0, alu_a=0, alu_b=0, done=0, illegal=0, result=0, instr_ready=1.
- Register file:
  - r0 reads 0 always; writes to r0 are discarded (done still pulses).
  - Write occurs on the WB edge only.
- FSM states: IDLE, ISSUE, WAIT, WB, FAULT.
- IDLE:
  - instr_ready=1. Accept on instr_valid and instr_ready at a clock edge.
  - On accept, latch opc, rd, alu_a<=reg[ra], alu_b<=reg[rb], imm.
  - Next state by opcode:
    - opc 1..10 -> ISSUE.
    - opc 11 (LDI) -> WB.
    - opc 0 (NOP) -> WB with no write.
    - opc 12..15 -> FAULT.
- ISSUE:
  - Lasts exactly 1 cycle; alu_op=opc and the ALU samples it on the closing edge.
  - ALU_LAT=1 -> WB; otherwise -> WAIT with counter=ALU_LAT-1.
- WAIT:
  - alu_op=0 so the ALU holds its output. The counter decrements each cycle.
  - Leave for WB when the counter reaches 1.
- WB:
  - done=1 for this single cycle.
  - Write data: alu_out for ALU ops, zero-extended imm9 for LDI.
  - On the closing edge, reg[rd]<=wdata (skipped for NOP and r0) and result<=wdata (NOP leaves result unchanged). Next state IDLE.
- FAULT: illegal=1 for one cycle, no register write, result unchanged, -> IDLE.
- Timing:
  - instr_ready=0 in every state except IDLE.
  - alu_op=0 in every state except ISSUE.
  - Latency from the accept edge to done: ALU op = 1+ALU_LAT cycles; LDI/NOP = 1 cycle.
  - Back-to-back instructions: the next accept can occur on the WB closing edge's following IDLE cycle, so ALU op throughput is one per 2+ALU_LAT cycles.
- Hazards: none. Execution is strictly serial, so an instruction reading rd of the previous one sees the written value.
- Arithmetic semantics are owned by the ALU; the controller passes full 16-bit operands and stores alu_out unmodified.
- Reset mid-instruction: abort immediately; no write, no done, no illegal. The instruction is not retried.
- alu_a/alu_b hold their last values outside ISSUE.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_IDLE..OP_EQ (0..10), OP_LDI=11.
  - Instruction field position constants.
  - FSM state encoding.
  - DATA_W default.
  - The ALU's constants also move into this package.
- One natural sub-module: regfile_8x16. It provides 2 read ports, 1 debug read port and 1 write port, with r0 hardwired zero and async reset to zero.

Test Plan:
- LDI r1,#5; LDI r2,#3; ADD r3,r1,r2 (ALU model, ALU_LAT=1) -> done after 1,1,2 cycles; alu_op=1 for exactly one cycle; dbg r3=8; result=8.
- SUB r4,r2,r1 -> r4=0xFFFE. Then GT r5,r1,r2 -> r5=1, and EQ r6,r1,r1 -> r6=1.
- LDI r0,#7 then dbg r0 -> 0. done pulses once; instr_ready low during the busy cycle.
- instr opc=13 -> illegal pulse exactly 1 cycle after accept; no done; all regs unchanged. opc=0 -> done after 1 cycle, result unchanged.
- ALU_LAT=3, ADD r3,r1,r2 -> alu_op=1 for 1 cycle then 0; done 4 cycles after accept; r3=8.
- Assert reset during the ISSUE cycle of ADD r7,r1,r2 -> state IDLE, r1=r7=0, no done; instr_ready=1 on the first cycle after reset deasserts.
